// File: rtl/sm_ahb_ram_slave.sv
// AHB-Lite single-port RAM slave with programmable wait states and
// two-cycle ERROR response for unaligned or out-of-range transfers.
module sm_ahb_ram_slave #(
  parameter int unsigned SIZE = 64,
  parameter int unsigned WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    ERR1   = 2'd2,
    ERR2   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] idx;
  logic          wr;
  logic          accept;
  logic          addr_err;
  logic          complete;
  logic          unused_htrans0;

  logic [31:0]   mem [SIZE];

  // HTRANS[0] only distinguishes SEQ from NONSEQ, which this slave treats alike
  assign unused_htrans0 = HTRANS[0];

  assign accept   = HSEL & HTRANS[1] & HREADY & ~rst;
  assign addr_err = (HADDR[1:0] != 2'b00) || (HADDR[31:2] >= 30'(SIZE));
  assign complete = (state == WAITST) && (cnt == '0);

  // State register plus address-phase capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx <= HADDR[AW+1:2];
        wr  <= HWRITE;
      end
    end
  end

  // Next state: an in-flight wait or ERR1 takes priority over new acceptance
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ERR1) begin
      state_nxt = ERR2;
    end else if ((state == WAITST) && (cnt != '0)) begin
      cnt_nxt = cnt - CW'(1);
    end else if (accept) begin
      if (addr_err) begin
        state_nxt = ERR1;
        cnt_nxt   = '0;
      end else begin
        state_nxt = WAITST;
        cnt_nxt   = CW'(WAIT);
      end
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state)
      WAITST: begin
        HREADYOUT = (cnt == '0);
        if (!wr) HRDATA = mem[idx];
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2:    HRESP = 1'b1;
      default: ;
    endcase
  end

  // Write lands only on the completing cycle; storage itself is never reset
  always_ff @(posedge clk) begin
    if (!rst && complete && wr) mem[idx] <= HWDATA;
  end

endmodule

// File: tb/tb_sm_ahb_ram_slave.sv
// Scoreboard bench: two slaves (WAIT=2 and WAIT=0), directed transfers,
// per-data-phase-cycle expectations popped by an independent monitor.
module tb_sm_ahb_ram_slave;

  localparam int unsigned SIZE = 64;

  typedef struct packed {
    logic        ready;
    logic        resp;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic        hwrite    [2];
  logic [1:0]  htrans    [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  logic [31:0] model [2][SIZE];
  exp_t        exp_q [$];
  logic        dphase [2];
  logic        mon_en;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sm_ahb_ram_slave #(.SIZE(SIZE), .WAIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HTRANS(htrans[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  sm_ahb_ram_slave #(.SIZE(SIZE), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HTRANS(htrans[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", name, d, $time, got, want);
    end
  endtask

  task automatic push(input logic r, input logic s, input logic [31:0] dt);
    exp_t e;
    e.ready = r;
    e.resp  = s;
    e.data  = dt;
    exp_q.push_back(e);
  endtask

  // Monitor: every data-phase cycle consumes one expectation, other cycles must look idle
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (dphase[d]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_data_phase dut%0d t=%0t got busy want none", d, $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("hreadyout", d, 32'(hreadyout[d]), 32'(e.ready));
            chk("hresp", d, 32'(hresp[d]), 32'(e.resp));
            chk("hrdata", d, hrdata[d], e.data);
          end
        end else begin
          chk("idle_hreadyout", d, 32'(hreadyout[d]), 32'd1);
          chk("idle_hresp", d, 32'(hresp[d]), 32'd0);
          chk("idle_hrdata", d, hrdata[d], 32'd0);
        end
        if (rst) dphase[d] <= 1'b0;
        else if (hsel[d] && htrans[d][1] && hreadyout[d]) dphase[d] <= 1'b1;
        else if (hreadyout[d]) dphase[d] <= 1'b0;
      end
    end
  end

  // Issue one transfer; expectations are pushed once it is accepted
  task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit abort);
    bit ok;
    bit err;
    int w;
    logic [5:0]  ix;
    logic [31:0] rd;
    hsel[d]   = 1'b1;
    htrans[d] = 2'b10;
    haddr[d]  = addr;
    hwrite[d] = wr;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hreadyout[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout dut%0d got no HREADY want accept", d);
    end
    @(posedge clk);
    #1;
    w   = (d == 0) ? 2 : 0;
    err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(SIZE));
    ix  = addr[7:2];
    if (err) begin
      push(1'b0, 1'b1, 32'h0);
      push(1'b1, 1'b1, 32'h0);
    end else begin
      rd = wr ? 32'h0 : model[d][ix];
      for (int k = 0; k < w; k++) push(1'b0, 1'b0, rd);
      if (!abort) begin
        push(1'b1, 1'b0, rd);
        if (wr) model[d][ix] = wdata;
      end
    end
    hwdata[d] = wdata;
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    haddr[d]  = $urandom;
    hwrite[d] = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    mon_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      dphase[d] = 1'b0;
      hsel[d]   = 1'b0;
      htrans[d] = 2'b00;
      haddr[d]  = 32'h0;
      hwrite[d] = 1'b0;
      hwdata[d] = 32'h0;
    end
    // Transfer presented while reset is high must be ignored
    rst       = 1'b1;
    hsel[0]   = 1'b1;
    htrans[0] = 2'b10;
    haddr[0]  = 32'h0000_0100;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle_cycles(2);
    rst       = 1'b0;
    hsel[0]   = 1'b0;
    htrans[0] = 2'b00;
    idle_cycles(1);

    // WAIT=2 slave
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    idle_cycles(3);
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0);
    issue(0, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 1'b0);
    issue(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0);
    issue(0, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h0000_0006, 32'hFFFF_0000, 1'b0);
    issue(0, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0);
    issue(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    idle_cycles(3);

    // Reset in the second wait cycle aborts the write
    issue(0, 1'b1, 32'h0000_0020, 32'h3333_4444, 1'b1);
    idle_cycles(1);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(1);
    issue(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    idle_cycles(2);

    // Selected but BUSY/IDLE: no access
    for (int i = 0; i < 5; i++) begin
      hsel[0]   = 1'b1;
      htrans[0] = (i % 2 == 0) ? 2'b01 : 2'b00;
      haddr[0]  = 32'h0000_0010;
      hwrite[0] = 1'b1;
      hwdata[0] = $urandom;
      idle_cycles(1);
    end
    hsel[0]   = 1'b0;
    htrans[0] = 2'b00;
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    idle_cycles(4);

    // WAIT=0 slave: one transfer per cycle
    issue(1, 1'b1, 32'h0000_0000, 32'h1000_0001, 1'b0);
    issue(1, 1'b1, 32'h0000_0004, 32'h2000_0002, 1'b0);
    issue(1, 1'b1, 32'h0000_0008, 32'h3000_0003, 1'b0);
    issue(1, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0);
    issue(1, 1'b0, 32'h0000_00FC, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h0000_0104, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    idle_cycles(4);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm_ahb_ram_slave.md
SM_AHB_RAM_SLAVE -- requirements
Module: sm_ahb_ram_slave

Interface
REQ-001 Parameter SIZE, default 64: memory depth in 32-bit words; SHALL be a power of two, 2..4096.
REQ-002 Parameter WAIT, default 2: wait states inserted per OKAY transfer; SHALL be in range 0..15.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port HSEL  input  1: slave select from the address decoder.
REQ-006 Port HADDR  input  32: byte address (address phase).
REQ-007 Port HWRITE  input  1: 1 = write, 0 = read (address phase).
REQ-008 Port HTRANS  input  2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 Port HWDATA  input  32: write data (data phase).
REQ-010 Port HREADY  input  1: bus-level ready; high means the previous transfer completes this cycle.
REQ-011 Port HRDATA  output  32: read data (data phase).
REQ-012 Port HREADYOUT  output  1: this slave's ready.
REQ-013 Port HRESP  output  1: 0 = OKAY, 1 = ERROR.

Function
REQ-014 Address phase accepted iff HSEL & HTRANS[1] & HREADY at a rising edge; HADDR and HWRITE SHALL be registered on that edge.
REQ-015 HSEL with HTRANS IDLE/BUSY, or HSEL low: no access; next cycle HREADYOUT=1, HRESP=0.
REQ-016 Accepted transfer SHALL be an error if HADDR[1:0]!=0 or HADDR[31:2] >= SIZE; else OKAY. Word index = HADDR[2+log2(SIZE)-1:2].
REQ-017 FSM states: IDLE, WAITST, ERR1, ERR2.
REQ-018 IDLE: HREADYOUT=1, HRESP=0; on accepted OKAY transfer -> WAITST with counter=WAIT; on accepted error transfer -> ERR1.
REQ-019 WAITST: HREADYOUT = (counter==0), HRESP=0; counter decrements each cycle while nonzero.
REQ-020 WAITST exit on the counter==0 cycle: to WAITST (counter reloaded to WAIT) if a new OKAY transfer is accepted that edge, to ERR1 if a new error transfer is accepted, else to IDLE.
REQ-021 WAIT=0: each OKAY data phase SHALL complete in exactly 1 cycle; back-to-back transfers SHALL sustain 1 transfer/cycle.
REQ-022 Write: mem[index] <= HWDATA on the edge ending the completing cycle (HREADYOUT=1 in WAITST); no write during earlier wait cycles.
REQ-023 Read: HRDATA = mem[index] during every WAITST cycle of a read; HRDATA = 0 in all other states and during writes.
REQ-024 Read in the data phase immediately following a write to the same word SHALL return the newly written value.
REQ-025 ERR1: HREADYOUT=0, HRESP=1, no memory access; always -> ERR2 next cycle.
REQ-026 ERR2: HREADYOUT=1, HRESP=1; exit as in REQ-020 (new transfer accepted in ERR2 is honoured).
REQ-027 Wait states SHALL NOT apply to error transfers (always exactly 2 cycles).
REQ-028 HTRANS changed to IDLE by the master during ERR1 (cancellation) SHALL be tolerated; REQ-014 alone governs acceptance.
REQ-029 HWDATA, HADDR, HWRITE are don't-care outside their phases; X on them SHALL NOT corrupt memory.

Reset
REQ-030 rst high at an edge: state=IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0, registered address/write cleared; held while rst high.
REQ-031 rst during WAITST SHALL abort the transfer with no memory write; memory contents are not reset.
REQ-032 Transfer presented in the cycle rst is high SHALL NOT be accepted.

Verification
REQ-033 WAIT=2: write 0xDEADBEEF to 0x00000010 -> HREADYOUT 0,0,1 over data phase; later read of 0x10 -> HRDATA=0xDEADBEEF on completing cycle, HRESP=0.
REQ-034 WAIT=0: NONSEQ writes to 0x0,0x4,0x8 back-to-back, then reads -> one transfer/cycle, HREADYOUT constantly 1, data 1:1 match.
REQ-035 SIZE=64: read 0x00000100 -> HREADYOUT=0,HRESP=1 then HREADYOUT=1,HRESP=1; then OKAY read of 0x0 accepted in ERR2 completes normally.
REQ-036 Unaligned write to 0x00000006 -> 2-cycle ERROR, memory word 1 unchanged.
REQ-037 rst asserted in second wait cycle of a write to 0x20 -> next cycle HREADYOUT=1, HRESP=0; read of 0x20 returns prior value.
REQ-038 HSEL=1, HTRANS=BUSY/IDLE for 5 cycles -> HREADYOUT=1, HRESP=0, no memory change.
